// File: rtl/lcd_frame_stream_ctrl.sv
// HX8352-class LCD top sequencer: hardware reset timing, init hand-off,
// then GRAM-write command plus one full frame of streamed pixels.
module lcd_frame_stream_ctrl #(
  parameter int          DATA_W       = 16,
  parameter int          CMD_W        = 8,
  parameter int          CNT_W        = 20,
  parameter int          RST_LOW_CYC  = 50000,
  parameter int          RST_WAIT_CYC = 60000,
  parameter int          H_RES        = 240,
  parameter int          V_RES        = 400,
  parameter logic [CMD_W-1:0] WRITE_CMD = 8'h22,
  parameter bit          CONTINUOUS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reinit,
  input  logic              frame_go,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              init_start,
  input  logic              init_done,
  input  logic              init_bus_step,
  input  logic              init_cmd_data,
  input  logic [DATA_W-1:0] init_bus_data,
  output logic              bus_step,
  output logic              bus_cmd_data,
  output logic [DATA_W-1:0] bus_data,
  input  logic              bus_done,
  output logic              lcd_cs,
  output logic              lcd_rst,
  output logic              frame_start,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_INIT,
    S_IDLE,
    S_FRM_CMD,
    S_FRM_CMD_W,
    S_PIX,
    S_PIX_W
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              step_q;
  logic              cd_q;
  logic [DATA_W-1:0] data_q;

  logic rst_hit;
  logic wait_hit;
  logic init_end;
  logic frame_begin;
  logic take_pix;
  logic pix_adv;
  logic frame_end;
  logic x_last;
  logic y_last;

  assign x_last = (x_q == XW'(H_RES - 1));
  assign y_last = (y_q == YW'(V_RES - 1));

  always_comb begin
    state_d     = state_q;
    rst_hit     = 1'b0;
    wait_hit    = 1'b0;
    init_end    = 1'b0;
    frame_begin = 1'b0;
    take_pix    = 1'b0;
    pix_adv     = 1'b0;
    frame_end   = 1'b0;
    unique case (state_q)
      S_RST_LOW: begin
        if (cnt_q == CNT_W'(RST_LOW_CYC - 1)) begin
          rst_hit = 1'b1;
          state_d = S_RST_WAIT;
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_WAIT_CYC - 1)) begin
          wait_hit = 1'b1;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        if (init_done) begin
          init_end = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_IDLE: begin
        if (CONTINUOUS || frame_go) begin
          frame_begin = 1'b1;
          state_d     = S_FRM_CMD;
        end
      end
      S_FRM_CMD: state_d = S_FRM_CMD_W;
      S_FRM_CMD_W: begin
        if (bus_done) state_d = S_PIX;
      end
      S_PIX: begin
        if (pix_valid) begin
          take_pix = 1'b1;
          state_d  = S_PIX_W;
        end
      end
      S_PIX_W: begin
        if (bus_done) begin
          pix_adv = 1'b1;
          if (x_last && y_last) begin
            frame_end = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_PIX;
          end
        end
      end
      default: state_d = S_RST_LOW;
    endcase
    // reinit wins: drop every pending action of the current state
    if (reinit) begin
      state_d     = S_RST_LOW;
      rst_hit     = 1'b0;
      wait_hit    = 1'b0;
      init_end    = 1'b0;
      frame_begin = 1'b0;
      take_pix    = 1'b0;
      pix_adv     = 1'b0;
      frame_end   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RST_LOW;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      step_q      <= 1'b0;
      cd_q        <= 1'b0;
      data_q      <= '0;
      pix_ready   <= 1'b0;
      init_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      lcd_cs      <= 1'b1;
      lcd_rst     <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state_q     <= state_d;
      busy        <= (state_d != S_IDLE);
      step_q      <= 1'b0;
      pix_ready   <= 1'b0;
      init_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      if (reinit || rst_hit || wait_hit) begin
        cnt_q <= '0;
      end else if (state_q == S_RST_LOW || state_q == S_RST_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (reinit) begin
        lcd_rst <= 1'b0;
        lcd_cs  <= 1'b1;
        x_q     <= '0;
        y_q     <= '0;
      end
      if (rst_hit) lcd_rst <= 1'b1;
      if (wait_hit) begin
        init_start <= 1'b1;
        lcd_cs     <= 1'b0;
      end
      if (init_end) lcd_cs <= 1'b1;
      if (frame_begin) begin
        lcd_cs      <= 1'b0;
        step_q      <= 1'b1;
        cd_q        <= 1'b0;
        data_q      <= DATA_W'(WRITE_CMD);
        frame_start <= 1'b1;
        x_q         <= '0;
        y_q         <= '0;
      end
      if (take_pix) begin
        pix_ready <= 1'b1;
        step_q    <= 1'b1;
        cd_q      <= 1'b1;
        data_q    <= pix_data;
      end
      if (pix_adv) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      if (frame_end) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
        lcd_cs     <= 1'b1;
      end
    end
  end

  // init sequencer owns the bus combinationally while in INIT
  always_comb begin
    bus_step     = step_q;
    bus_cmd_data = cd_q;
    bus_data     = data_q;
    if (state_q == S_INIT) begin
      bus_step     = init_bus_step;
      bus_cmd_data = init_cmd_data;
      bus_data     = init_bus_data;
    end
  end

endmodule

// File: tb/tb_lcd_frame_stream_ctrl.sv
// Scoreboard bench for lcd_frame_stream_ctrl: random pixel frames,
// reset timing, init bus hand-off, stalls, reinit and frame_go gating.
module tb_lcd_frame_stream_ctrl;

  localparam int DW    = 16;
  localparam int H     = 4;
  localparam int V     = 2;
  localparam int NPIX  = H * V;
  localparam int LOWC  = 4;
  localparam int WAITC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          reinit;
  logic          frame_go;
  logic [DW-1:0] pix_data = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic          init_start;
  logic          init_done;
  logic          init_bus_step;
  logic          init_cmd_data;
  logic [DW-1:0] init_bus_data;
  logic          bus_step;
  logic          bus_cmd_data;
  logic [DW-1:0] bus_data;
  logic          bus_done = 1'b0;
  logic          lcd_cs;
  logic          lcd_rst;
  logic          frame_start;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          busy;

  lcd_frame_stream_ctrl #(
    .DATA_W(DW), .CMD_W(8), .CNT_W(20),
    .RST_LOW_CYC(LOWC), .RST_WAIT_CYC(WAITC),
    .H_RES(H), .V_RES(V),
    .WRITE_CMD(8'h22), .CONTINUOUS(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .reinit(reinit), .frame_go(frame_go),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .init_start(init_start), .init_done(init_done),
    .init_bus_step(init_bus_step), .init_cmd_data(init_cmd_data),
    .init_bus_data(init_bus_data),
    .bus_step(bus_step), .bus_cmd_data(bus_cmd_data), .bus_data(bus_data),
    .bus_done(bus_done), .lcd_cs(lcd_cs), .lcd_rst(lcd_rst),
    .frame_start(frame_start), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic [15:0] src_q[$];
  bit          gap = 1'b0;
  bit          in_init = 1'b1;
  int          pops = 0;
  int          done_seen = 0;
  int          fs_seen = 0;
  int          fs_exp = 0;
  int          data_writes = 0;
  int          pend = 0;
  logic        valid_q = 1'b0;
  logic        done_q = 1'b0;
  logic [16:0] e;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    valid_q <= pix_valid;
    done_q  <= bus_done;
  end

  // pixel source: a queue presented over valid/ready
  always @(negedge clk) begin
    if (pix_ready) begin
      chk("ready_without_valid", {31'd0, valid_q}, 32'd1);
      if (src_q.size() > 0) void'(src_q.pop_front());
      pops++;
    end
    if (src_q.size() > 0 && !gap) begin
      pix_valid = 1'b1;
      pix_data  = src_q[0];
    end else begin
      pix_valid = 1'b0;
      pix_data  = 16'($urandom);
    end
  end

  // bus engine: bus_done two cycles after each step
  always @(negedge clk) begin
    bus_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) bus_done = 1'b1;
    end
    if (bus_step) begin
      if (!in_init) chk("one_outstanding", pend, 0);
      pend = 2;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (bus_step && !in_init) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected none",
                 {bus_cmd_data, bus_data});
      end else begin
        e = exp_q.pop_front();
        chk("bus_write", {15'd0, bus_cmd_data, bus_data}, {15'd0, e});
      end
      if (bus_cmd_data) data_writes++;
    end
    if (gap && !valid_q)
      chk("gap_quiet", {30'd0, pix_ready, bus_step & bus_cmd_data}, 32'd0);
    if (frame_start) fs_seen++;
    if (frame_done) begin
      done_seen++;
      chk("done_with_last_bus_done", {31'd0, done_q}, 32'd1);
      chk("frame_cnt", {16'd0, frame_cnt}, done_seen);
      chk("frame_all_writes", exp_q.size(), 0);
    end
  end

  task automatic bring_up(bit bus_test);
    int low = 0;
    int wt = 0;
    int n = 0;
    while (!lcd_rst && n < 200) begin
      low++; n++;
      @(negedge clk);
    end
    chk("lcd_rst_low_cycles", low, LOWC);
    while (!init_start && n < 200) begin
      wt++; n++;
      @(negedge clk);
    end
    chk("init_start_delay", wt, WAITC);
    chk("init_cs_low", {31'd0, lcd_cs}, 32'd0);
    if (bus_test) begin
      init_bus_data = 16'h00A5;
      init_cmd_data = 1'b1;
      init_bus_step = 1'b1;
      #1;
      chk("init_mux_step", {31'd0, bus_step}, 32'd1);
      chk("init_mux_data", {16'd0, bus_data}, 32'h00A5);
      chk("init_mux_cd", {31'd0, bus_cmd_data}, 32'd1);
      @(negedge clk);
      init_bus_step = 1'b0;
      repeat (3) @(negedge clk);
    end
    init_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20);
    init_done = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cs", {31'd0, lcd_cs}, 32'd1);
    in_init = 1'b0;
  endtask

  task automatic run_frame(bit do_gap, bit do_busy_go, bit do_reinit);
    logic [15:0] p;
    int  n = 0;
    int  base = data_writes;
    int  target = done_seen + 1;
    bit  gap_done = 0;
    bit  go_done = 0;
    exp_q.push_back({1'b0, 16'h0022});
    for (int i = 0; i < NPIX; i++) begin
      p = 16'($urandom);
      src_q.push_back(p);
      exp_q.push_back({1'b1, p});
    end
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    fs_exp++;
    chk("frame_start_after_go", {31'd0, frame_start}, 32'd1);
    chk("frame_busy", {31'd0, busy}, 32'd1);
    chk("frame_cs_low", {31'd0, lcd_cs}, 32'd0);
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (do_busy_go && !go_done && pops % NPIX == 2) begin
        frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        go_done = 1;
      end
      if (do_gap && !gap_done && pops % NPIX == 4) begin
        gap = 1'b1;
        repeat (5) @(negedge clk);
        gap = 1'b0;
        gap_done = 1;
      end
      if (do_reinit && pops % NPIX == 3) begin
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        return;
      end
      if (done_seen == target) break;
    end
    chk("frame_completed", done_seen, target);
    chk("frame_data_writes", data_writes - base, NPIX);
    repeat (6) @(negedge clk);
    chk("no_extra_frame_start", fs_seen, fs_exp);
    chk("back_to_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    reinit = 1'b0;
    frame_go = 1'b0;
    init_done = 1'b0;
    init_bus_step = 1'b0;
    init_cmd_data = 1'b0;
    init_bus_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_lcd_rst", {31'd0, lcd_rst}, 32'd0);
    chk("rst_lcd_cs", {31'd0, lcd_cs}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_bus_step", {31'd0, bus_step}, 32'd0);
    chk("rst_bus_data", {16'd0, bus_data}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_pulses", {28'd0, frame_start, frame_done, pix_ready, init_start}, 32'd0);
    rst = 1'b0;
    bring_up(1'b1);

    run_frame(1'b0, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);

    run_frame(1'b0, 1'b0, 1'b1);
    chk("reinit_lcd_rst", {31'd0, lcd_rst}, 32'd0);
    chk("reinit_lcd_cs", {31'd0, lcd_cs}, 32'd1);
    chk("reinit_busy", {31'd0, busy}, 32'd1);
    exp_q.delete();
    src_q.delete();
    in_init = 1'b1;
    bring_up(1'b0);
    chk("reinit_cnt_kept", {16'd0, frame_cnt}, 32'd2);
    chk("reinit_no_done", done_seen, 2);

    run_frame(1'b0, 1'b0, 1'b0);
    chk("final_frame_cnt", {16'd0, frame_cnt}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
